// File: rtl/sr_drv_pkg.sv
// Shared types and S/R drive encodings for the SR flip-flop driver.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_e;

  // {S,R} drive codes; ILL must never reach the flop.
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] ILL  = 2'b11;

endpackage

// File: rtl/sr_ff_driver_if.sv
// S/R driver bundle: sequence control, flop drive and feedback, status.
interface sr_ff_driver_if #(
  parameter int W  = 8,
  parameter int LW = $clog2(W + 1)
) ();

  logic          START;
  logic [W-1:0]  PATTERN;
  logic [LW-1:0] LEN;
  logic          Q_FB;
  logic          S;
  logic          R;
  logic          BUSY;
  logic          DONE;
  logic          ERR;
  logic [LW-1:0] BIT_IDX;

  // Driver side.
  modport master (
    input  START, PATTERN, LEN, Q_FB,
    output S, R, BUSY, DONE, ERR, BIT_IDX
  );

  // Fixture side: issues sequences and closes the loop through the flop.
  modport slave (
    output START, PATTERN, LEN, Q_FB,
    input  S, R, BUSY, DONE, ERR, BIT_IDX
  );

endinterface

// File: rtl/sr_excite.sv
// SR excitation: maps target bit and known flop state onto a legal {S,R} code.
module sr_excite
  import sr_drv_pkg::*;
(
  input  logic       t_i,
  input  logic       m_i,
  input  logic       mv_i,
  input  logic       force_i,
  output logic [1:0] sr_o
);

  // Only an unknown or differing flop state needs an active drive.
  always_comb begin
    sr_o = HOLD;
    if (force_i || !mv_i || (t_i != m_i)) begin
      sr_o = t_i ? SET : RST;
    end
  end

endmodule

// File: rtl/sr_ff_driver.sv
// SR flop sequence driver: applies a target Q pattern LSB first and checks Q feedback.
// Build option SR_DRV_FORCE_EN: drive SET/RST every bit instead of holding when Q already matches.
module sr_ff_driver
  import sr_drv_pkg::*;
#(
  parameter int W  = 8,
  parameter int LW = $clog2(W + 1)
) (
  input  logic           CLK,
  input  logic           RST_N,
  sr_ff_driver_if.master bus
);

`ifdef SR_DRV_FORCE_EN
  localparam logic FORCE_DRV = 1'b1;
`else
  localparam logic FORCE_DRV = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic          m_q, m_d;
  logic          mv_q, mv_d;
  logic          s_q, r_q, busy_q, done_q;
  logic [LW-1:0] len_clamp;
  logic          match;
  logic [1:0]    ex_sr;

  assign len_clamp = (bus.LEN > LW'(W)) ? LW'(W) : bus.LEN;

  // The excitation for the next DRIVE cycle sees the post-update pattern and model.
  sr_excite u_excite (
    .t_i     (pat_d[0]),
    .m_i     (m_d),
    .mv_i    (mv_d),
    .force_i (FORCE_DRV),
    .sr_o    (ex_sr)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    err_d   = err_q;
    m_d     = m_q;
    mv_d    = mv_q;
    // An X/Z feedback fails the equality test and falls through as a mismatch.
    match   = 1'b0;
    if (bus.Q_FB == pat_q[0]) match = 1'b1;

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (bus.START) begin
          pat_d   = bus.PATTERN;
          len_d   = len_clamp;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = (len_clamp == '0) ? FIN : DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (!match) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          m_d  = pat_q[0];
          mv_d = 1'b1;
          if (idx_q == len_q - LW'(1)) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + LW'(1);
            pat_d   = pat_q >> 1;
            state_d = DRIVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      m_q     <= 1'b0;
      mv_q    <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      m_q     <= m_d;
      mv_q    <= mv_d;
      s_q     <= (state_d == DRIVE) ? ex_sr[1] : 1'b0;
      r_q     <= (state_d == DRIVE) ? ex_sr[0] : 1'b0;
      busy_q  <= (state_d == DRIVE) || (state_d == CHECK);
      done_q  <= (state_q == FIN);
    end
  end

  // Pattern and length are only meaningful after a START, so they carry no reset.
  always_ff @(posedge CLK) begin
    pat_q <= pat_d;
    len_q <= len_d;
  end

  always @(posedge CLK) begin
    if (RST_N) assert ({s_q, r_q} != ILL);
  end

  assign bus.S       = s_q;
  assign bus.R       = r_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.ERR     = err_q;
  assign bus.BIT_IDX = idx_q;

endmodule

// File: tb/tb_sr_ff_driver.sv
// Directed bench for sr_ff_driver closing the loop through an ideal or stuck SR flop.
module tb_sr_ff_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fq;
  logic stuck = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  sr_ff_driver_if #(.W(8)) bus ();

  sr_ff_driver #(.W(8)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     fq <= 1'b0;
    else if (bus.S) fq <= 1'b1;
    else if (bus.R) fq <= 1'b0;
  end

  assign bus.Q_FB = stuck ? 1'b0 : fq;

  always @(negedge clk) begin
    n_cmp++;
    if ((bus.S & bus.R) !== 1'b0) begin
      n_bad++;
      $display("FAIL sr_exclusive: S=%b R=%b required not both 1", bus.S, bus.R);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.START = 1'b0; bus.PATTERN = '0; bus.LEN = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.S, bus.R, bus.BUSY, bus.DONE, bus.ERR, bus.BIT_IDX} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: S R BUSY DONE ERR IDX=%b required 0",
               {bus.S, bus.R, bus.BUSY, bus.DONE, bus.ERR, bus.BIT_IDX});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [1:0] exp_sr [8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    bus.START = 1'b1; bus.PATTERN = 8'b0000_0101; bus.LEN = 4'd3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.START = 1'b0;
      n_cmp++;
      if ({bus.S, bus.R} !== exp_sr[k]) begin
        n_bad++;
        $display("FAIL basic_sr k=%0d: got %b required %b", k, {bus.S, bus.R}, exp_sr[k]);
      end
      n_cmp++;
      if (bus.DONE !== (k == 7)) begin
        n_bad++;
        $display("FAIL basic_done k=%0d: got %b required %b", k, bus.DONE, (k == 7));
      end
    end
    n_cmp++;
    if (bus.ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_err: got %b required 0", bus.ERR);
    end
  endtask

  // Starts on the DONE cycle of the previous run; model m=1 allows holds.
  task automatic test_hold();
`ifdef SR_DRV_FORCE_EN
    logic [1:0] exp_sr [6] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
`else
    logic [1:0] exp_sr [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
`endif
    bus.START = 1'b1; bus.PATTERN = 8'b0000_0011; bus.LEN = 4'd2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.START = 1'b0;
      n_cmp++;
      if ({bus.S, bus.R} !== exp_sr[k]) begin
        n_bad++;
        $display("FAIL hold_sr k=%0d: got %b required %b", k, {bus.S, bus.R}, exp_sr[k]);
      end
      n_cmp++;
      if (bus.DONE !== (k == 5)) begin
        n_bad++;
        $display("FAIL hold_done k=%0d: got %b required %b", k, bus.DONE, (k == 5));
      end
      if (k == 2) begin
        n_cmp++;
        if (bus.BIT_IDX !== 4'd1) begin
          n_bad++;
          $display("FAIL hold_idx: got %0d required 1", bus.BIT_IDX);
        end
      end
    end
  endtask

  task automatic test_stuck();
    stuck = 1'b1;
    bus.START = 1'b1; bus.PATTERN = 8'b0000_0001; bus.LEN = 4'd4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.START = 1'b0;
      n_cmp++;
      if (bus.DONE !== (k == 3)) begin
        n_bad++;
        $display("FAIL stuck_done k=%0d: got %b required %b", k, bus.DONE, (k == 3));
      end
      if (k >= 2) begin
        n_cmp++;
        if ({bus.ERR, bus.BIT_IDX, bus.S, bus.R} !== 7'b1_0000_00) begin
          n_bad++;
          $display("FAIL stuck_state k=%0d: ERR IDX S R=%b required 1000000", k,
                   {bus.ERR, bus.BIT_IDX, bus.S, bus.R});
        end
      end
    end
    stuck = 1'b0;
  endtask

  task automatic test_len_zero();
    bus.START = 1'b1; bus.PATTERN = 8'hFF; bus.LEN = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.START = 1'b0;
      n_cmp++;
      if ({bus.S, bus.R, bus.BUSY, bus.ERR} !== 4'b0000) begin
        n_bad++;
        $display("FAIL len0_state k=%0d: S R BUSY ERR=%b required 0000", k,
                 {bus.S, bus.R, bus.BUSY, bus.ERR});
      end
      n_cmp++;
      if (bus.DONE !== (k == 1)) begin
        n_bad++;
        $display("FAIL len0_done k=%0d: got %b required %b", k, bus.DONE, (k == 1));
      end
    end
  endtask

  task automatic test_len_clamp();
    bus.START = 1'b1; bus.PATTERN = 8'hA5; bus.LEN = 4'd15;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      bus.START = 1'b0;
      n_cmp++;
      if (bus.DONE !== (k == 17)) begin
        n_bad++;
        $display("FAIL clamp_done k=%0d: got %b required %b", k, bus.DONE, (k == 17));
      end
      if (k == 16) begin
        n_cmp++;
        if (bus.BIT_IDX !== 4'd7) begin
          n_bad++;
          $display("FAIL clamp_idx: got %0d required 7", bus.BIT_IDX);
        end
      end
    end
    n_cmp++;
    if (bus.ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL clamp_err: got %b required 0", bus.ERR);
    end
  endtask

  task automatic test_start_busy();
    logic [1:0] exp_sr [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    bus.START = 1'b1; bus.PATTERN = 8'b0000_0010; bus.LEN = 4'd2;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bus.START = (k == 1);
      if (k == 1) begin
        bus.PATTERN = 8'hFF; bus.LEN = 4'd8;
      end
      n_cmp++;
      if ({bus.S, bus.R} !== exp_sr[k]) begin
        n_bad++;
        $display("FAIL busy_sr k=%0d: got %b required %b", k, {bus.S, bus.R}, exp_sr[k]);
      end
      n_cmp++;
      if (bus.DONE !== (k == 5)) begin
        n_bad++;
        $display("FAIL busy_done k=%0d: got %b required %b", k, bus.DONE, (k == 5));
      end
      n_cmp++;
      if (bus.BUSY !== (k >= 0 && k <= 3)) begin
        n_bad++;
        $display("FAIL busy_flag k=%0d: got %b required %b", k, bus.BUSY, (k <= 3));
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.START = 1'b1; bus.PATTERN = 8'b0000_0010; bus.LEN = 4'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.START = 1'b0;
    end
    n_cmp++;
    if (bus.S !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre_s: got %b required 1", bus.S);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.S, bus.R} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_async_sr: got %b required 00", {bus.S, bus.R});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.DONE, bus.BUSY} !== 2'b00) begin
        n_bad++;
        $display("FAIL mid_no_done k=%0d: DONE BUSY=%b required 00", k, {bus.DONE, bus.BUSY});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Model-valid is cleared by reset, so the first bit is driven even if Q may already match.
  task automatic test_model_reset();
    bus.START = 1'b1; bus.PATTERN = 8'h00; bus.LEN = 4'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.START = 1'b0;
      if (k == 0) begin
        n_cmp++;
        if ({bus.S, bus.R} !== 2'b01) begin
          n_bad++;
          $display("FAIL mv_first_sr: got %b required 01", {bus.S, bus.R});
        end
      end
      n_cmp++;
      if (bus.DONE !== (k == 3)) begin
        n_bad++;
        $display("FAIL mv_done k=%0d: got %b required %b", k, bus.DONE, (k == 3));
      end
    end
    n_cmp++;
    if (bus.ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL mv_err: got %b required 0", bus.ERR);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_stuck();
    test_len_zero();
    test_len_clamp();
    test_start_busy();
    test_reset_mid();
    test_model_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
